// File: rtl/traceback_64_pkg.sv
// traceback_64_pkg
// Shared definitions for the traceback block and the PE array: stripe
// geometry, op codes, direction-memory codes, the matrix selector, the
// traceback state encoding and helpers that clamp end coordinates.
package traceback_64_pkg;

  localparam int N_PE  = 64;
  localparam int N_COL = 400;
  localparam int ROW_W = 6;
  localparam int COL_W = 10;
  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    OP_M = 2'd0,
    OP_I = 2'd1,
    OP_D = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    VDIR_DIAG = 2'd0,
    VDIR_I    = 2'd1,
    VDIR_D    = 2'd2,
    VDIR_STOP = 2'd3
  } vdir_e;

  // Gap-matrix direction bit: 0 means the gap was opened from V.
  localparam logic DIR_OPEN = 1'b0;

  typedef enum logic [1:0] {
    MAT_V = 2'd0,
    MAT_I = 2'd1,
    MAT_D = 2'd2
  } mat_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_EVAL  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic stop;
    op_e  op;
    mat_e nextMat;
  } evalRes_t;

  // The one-bit extension keeps the comparison meaningful even when the
  // row port is exactly wide enough to address every PE.
  function automatic logic [ROW_W-1:0] clampRow(input logic [ROW_W-1:0] r);
    if ({1'b0, r} > (ROW_W+1)'(N_PE - 1)) return ROW_W'(N_PE - 1);
    return r;
  endfunction

  function automatic logic [COL_W-1:0] clampCol(input logic [COL_W-1:0] c);
    if ({1'b0, c} > (COL_W+1)'(N_COL - 1)) return COL_W'(N_COL - 1);
    return c;
  endfunction

endpackage

// File: rtl/traceback_64_if.sv
// traceback_64_if
// Bundles the traceback control inputs, the direction-memory read port and
// the op stream with its handshake.
//   master : the traceback block (drives o_*, receives i_*)
//   slave  : the environment (memory, op consumer, controller)
// Signals:
//   i_start, i_end_row, i_end_col        start pulse and start cell
//   o_rd_en, o_rd_row, o_rd_col          direction-memory read request
//   i_rd_v_dir, i_rd_i_dir, i_rd_d_dir   read data, one cycle after o_rd_en
//   o_op_valid, o_op, i_op_ready         alignment op stream
//   o_busy, o_done, o_op_count           status
interface traceback_64_if;
  import traceback_64_pkg::*;

  logic             i_start;
  logic [ROW_W-1:0] i_end_row;
  logic [COL_W-1:0] i_end_col;

  logic             o_rd_en;
  logic [ROW_W-1:0] o_rd_row;
  logic [COL_W-1:0] o_rd_col;
  logic [1:0]       i_rd_v_dir;
  logic             i_rd_i_dir;
  logic             i_rd_d_dir;

  logic             o_op_valid;
  op_e              o_op;
  logic             i_op_ready;

  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_op_count;

  modport master (
    input  i_start, i_end_row, i_end_col,
    input  i_rd_v_dir, i_rd_i_dir, i_rd_d_dir,
    input  i_op_ready,
    output o_rd_en, o_rd_row, o_rd_col,
    output o_op_valid, o_op,
    output o_busy, o_done, o_op_count
  );

  modport slave (
    output i_start, i_end_row, i_end_col,
    output i_rd_v_dir, i_rd_i_dir, i_rd_d_dir,
    output i_op_ready,
    input  o_rd_en, o_rd_row, o_rd_col,
    input  o_op_valid, o_op,
    input  o_busy, o_done, o_op_count
  );

endinterface

// File: rtl/traceback_64.sv
// traceback_64
// Walks the V/I/D direction matrices of a 64-row stripe backwards from a
// start cell and emits one alignment op (M, I or D) per step. Each step
// costs one memory read; once either the rows or the columns run out,
// the remaining ones are flushed as D or I ops without reads.
// Ports:
//   i_clk  clock
//   i_rst  synchronous active-high reset
//   bus    traceback_64_if.master (control, read port, op stream, status)
module traceback_64 (
  input  logic                  i_clk,
  input  logic                  i_rst,
  traceback_64_if.master        bus
);
  import traceback_64_pkg::*;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             rowExh_q, rowExh_d;
  logic             colExh_q, colExh_d;
  mat_e             mat_q, mat_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] opCount_q, opCount_d;

  evalRes_t         evalRes;
  logic             opValid;
  logic             handshake;
  logic             consumeRow;
  logic             consumeCol;

  // A V word pointing at I or D is resolved in the same step as if the
  // current matrix were I or D, so every read yields at most one op.
  function automatic evalRes_t evalDir(input mat_e  mat,
                                       input vdir_e vDir,
                                       input logic  iDir,
                                       input logic  dDir);
    evalRes_t res;
    mat_e     eff;
    res.stop    = 1'b0;
    res.op      = OP_M;
    res.nextMat = MAT_V;
    eff         = mat;
    if (mat == MAT_V) begin
      case (vDir)
        VDIR_DIAG: eff = MAT_V;
        VDIR_I:    eff = MAT_I;
        VDIR_D:    eff = MAT_D;
        default:   res.stop = 1'b1;
      endcase
    end
    case (eff)
      MAT_I: begin
        res.op      = OP_I;
        res.nextMat = (iDir == DIR_OPEN) ? MAT_V : MAT_I;
      end
      MAT_D: begin
        res.op      = OP_D;
        res.nextMat = (dDir == DIR_OPEN) ? MAT_V : MAT_D;
      end
      default: begin
        res.op      = OP_M;
        res.nextMat = MAT_V;
      end
    endcase
    return res;
  endfunction

  assign evalRes    = evalDir(mat_q, vdir_e'(bus.i_rd_v_dir),
                              bus.i_rd_i_dir, bus.i_rd_d_dir);
  assign opValid    = (state_q == ST_EMIT) || (state_q == ST_FLUSH);
  assign handshake  = opValid && bus.i_op_ready;
  assign consumeRow = (op_q == OP_M) || (op_q == OP_D);
  assign consumeCol = (op_q == OP_M) || (op_q == OP_I);

  // Row/col index 0 consumed means that axis is exhausted; the flags keep
  // the "past index 0" condition without widening the address registers.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    rowExh_d  = rowExh_q;
    colExh_d  = colExh_q;
    mat_d     = mat_q;
    op_d      = op_q;
    opCount_d = opCount_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          row_d     = clampRow(bus.i_end_row);
          col_d     = clampCol(bus.i_end_col);
          rowExh_d  = 1'b0;
          colExh_d  = 1'b0;
          mat_d     = MAT_V;
          opCount_d = '0;
          state_d   = ST_RD;
        end
      end
      ST_RD: state_d = ST_EVAL;
      ST_EVAL: begin
        if (evalRes.stop) begin
          state_d = ST_DONE;
        end else begin
          op_d    = evalRes.op;
          mat_d   = evalRes.nextMat;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT, ST_FLUSH: begin
        if (handshake) begin
          opCount_d = opCount_q + CNT_W'(1);
          if (consumeRow) begin
            if (row_q == '0) rowExh_d = 1'b1;
            else             row_d    = row_q - ROW_W'(1);
          end
          if (consumeCol) begin
            if (col_q == '0) colExh_d = 1'b1;
            else             col_d    = col_q - COL_W'(1);
          end
          if (rowExh_d && colExh_d) begin
            state_d = ST_DONE;
          end else if (rowExh_d || colExh_d) begin
            // Only one axis is left, so the flush op never changes.
            state_d = ST_FLUSH;
            op_d    = rowExh_d ? OP_I : OP_D;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      rowExh_q  <= 1'b0;
      colExh_q  <= 1'b0;
      mat_q     <= MAT_V;
      op_q      <= OP_M;
      opCount_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      rowExh_q  <= rowExh_d;
      colExh_q  <= colExh_d;
      mat_q     <= mat_d;
      op_q      <= op_d;
      opCount_q <= opCount_d;
    end
  end

  assign bus.o_rd_en    = (state_q == ST_RD);
  assign bus.o_rd_row   = row_q;
  assign bus.o_rd_col   = col_q;
  assign bus.o_op_valid = opValid;
  assign bus.o_op       = op_q;
  assign bus.o_busy     = (state_q != ST_IDLE);
  assign bus.o_done     = (state_q == ST_DONE);
  assign bus.o_op_count = opCount_q;

endmodule

// File: tb/tb_traceback_64.sv
// tb_traceback_64
// Drives traceback_64 through a table of fixed start cells, hand-written
// corner sequences (gap chains, stall, reset, ignored start) and random
// direction matrices. A direction-memory model answers reads one cycle
// after o_rd_en, and a reference walker computes the expected ops, read
// addresses and completion latency from the traceback rules.
module tb_traceback_64;
  import traceback_64_pkg::*;

  localparam int LIMIT = 4000;

  logic clk = 1'b0;
  logic rst;

  traceback_64_if bus();

  traceback_64 dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int readyMode = 1;

  logic [1:0] vMem [N_PE][N_COL];
  logic       iMem [N_PE][N_COL];
  logic       dMem [N_PE][N_COL];

  int opsSeen[$];
  int rdRowSeen[$];
  int rdColSeen[$];
  int expOps[$];
  int expRow[$];
  int expCol[$];
  int mReadOps;
  int mFlushOps;
  bit mStopped;

  int memRow;
  int memCol;
  assign memRow = int'(bus.o_rd_row);
  assign memCol = int'(bus.o_rd_col);

  typedef struct {
    int endRow;
    int endCol;
    int fill;
    int expCount;
    int expReads;
    int expFirstRow;
    int expFirstCol;
    int expLatency;
  } vec_t;

  vec_t vecs[7];

  // Downstream readiness changes on the falling edge only.
  always @(negedge clk)
    bus.i_op_ready = (readyMode == 2) ? 1'($urandom_range(0, 1)) : (readyMode == 1);

  // Direction memory with a fixed one-cycle read latency.
  always @(posedge clk) begin
    if (bus.o_rd_en) begin
      if (memCol < N_COL) begin
        bus.i_rd_v_dir <= vMem[memRow][memCol];
        bus.i_rd_i_dir <= iMem[memRow][memCol];
        bus.i_rd_d_dir <= dMem[memRow][memCol];
      end else begin
        bus.i_rd_v_dir <= 2'd3;
        bus.i_rd_i_dir <= 1'b0;
        bus.i_rd_d_dir <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.o_op_valid && bus.i_op_ready) opsSeen.push_back(int'(bus.o_op));
      if (bus.o_rd_en) begin
        rdRowSeen.push_back(int'(bus.o_rd_row));
        rdColSeen.push_back(int'(bus.o_rd_col));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic compareSeq(input string name, input int expQ[$], input int gotQ[$]);
    int bad;
    int n;
    bad = -1;
    n = (expQ.size() > gotQ.size()) ? expQ.size() : gotQ.size();
    for (int i = 0; i < n; i++) begin
      if (i >= expQ.size() || i >= gotQ.size() || expQ[i] != gotQ[i]) begin
        bad = i;
        break;
      end
    end
    checkOutput({name, " firstDiffIdx"}, bad, -1);
  endtask

  // kind 0: all DIAG, 1: all STOP, 2: V points at I with I opened from V,
  // 3: random with occasional STOP.
  task automatic fillMem(input int kind);
    for (int r = 0; r < N_PE; r++) begin
      for (int c = 0; c < N_COL; c++) begin
        case (kind)
          0: begin vMem[r][c] = 2'd0; iMem[r][c] = 1'b0; dMem[r][c] = 1'b0; end
          1: begin vMem[r][c] = 2'd3; iMem[r][c] = 1'b0; dMem[r][c] = 1'b0; end
          2: begin vMem[r][c] = 2'd1; iMem[r][c] = 1'b0; dMem[r][c] = 1'b0; end
          default: begin
            vMem[r][c] = ($urandom_range(0, 99) < 3) ? 2'd3 : 2'($urandom_range(0, 2));
            iMem[r][c] = 1'($urandom_range(0, 1));
            dMem[r][c] = 1'($urandom_range(0, 1));
          end
        endcase
      end
    end
  endtask

  // Reference walk over signed coordinates; -1 on an axis means exhausted.
  function automatic void modelWalk(input int er, input int ec);
    int r;
    int c;
    int mat;
    int m;
    int op;
    r = (er > N_PE - 1) ? N_PE - 1 : er;
    c = (ec > N_COL - 1) ? N_COL - 1 : ec;
    mat = 0;
    expOps.delete();
    expRow.delete();
    expCol.delete();
    mReadOps = 0;
    mFlushOps = 0;
    mStopped = 1'b0;
    while (r >= 0 && c >= 0) begin
      expRow.push_back(r);
      expCol.push_back(c);
      m = mat;
      if (m == 0) begin
        if (vMem[r][c] == 2'd3) begin
          mStopped = 1'b1;
          break;
        end else if (vMem[r][c] == 2'd1) m = 1;
        else if (vMem[r][c] == 2'd2) m = 2;
      end
      if (m == 1) begin
        op = 1;
        mat = iMem[r][c] ? 1 : 0;
      end else if (m == 2) begin
        op = 2;
        mat = dMem[r][c] ? 2 : 0;
      end else begin
        op = 0;
        mat = 0;
      end
      expOps.push_back(op);
      mReadOps++;
      if (op != 1) r--;
      if (op != 2) c--;
    end
    if (!mStopped) begin
      while (r >= 0) begin expOps.push_back(2); r--; mFlushOps++; end
      while (c >= 0) begin expOps.push_back(1); c--; mFlushOps++; end
    end
  endfunction

  // Starts a traceback, optionally injecting a second start at cycle
  // injectAt, and returns when o_done is seen or the budget runs out.
  task automatic applyStimulus(input int er, input int ec, input int mode,
                               input int injectAt,
                               output int doneCyc, output int firstValid);
    readyMode = mode;
    opsSeen.delete();
    rdRowSeen.delete();
    rdColSeen.delete();
    bus.i_end_row = 6'(er);
    bus.i_end_col = 10'(ec);
    bus.i_start = 1'b1;
    tick();
    doneCyc = 1;
    firstValid = -1;
    bus.i_start = 1'b0;
    while (!bus.o_done && doneCyc < LIMIT) begin
      if (bus.o_op_valid && firstValid < 0) firstValid = doneCyc;
      bus.i_start = (doneCyc == injectAt);
      if (doneCyc == injectAt) begin
        bus.i_end_row = 6'd1;
        bus.i_end_col = 10'd1;
      end
      tick();
      doneCyc++;
    end
    bus.i_start = 1'b0;
    if (!bus.o_done) checkOutput("doneReached", 0, 1);
  endtask

  initial begin
    int cyc;
    int fv;
    int er;
    int ec;
    int mode;
    int savedOp;
    int k;
    bit stable;

    vecs[0] = '{5, 5, 0, 6, 6, 5, 5, 19};
    vecs[1] = '{3, 10, 0, 11, 4, 3, 10, 20};
    vecs[2] = '{0, 0, 0, 1, 1, 0, 0, 4};
    vecs[3] = '{63, 500, 0, 400, 64, 63, 399, 529};
    vecs[4] = '{63, 399, 0, 400, 64, 63, 399, 529};
    vecs[5] = '{7, 7, 1, 0, 1, 7, 7, 3};
    vecs[6] = '{2, 4, 2, 8, 5, 2, 4, 19};

    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_end_row = '0;
    bus.i_end_col = '0;
    bus.i_rd_v_dir = 2'd0;
    bus.i_rd_i_dir = 1'b0;
    bus.i_rd_d_dir = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    checkOutput("resetBusy", int'(bus.o_busy), 0);
    checkOutput("resetDone", int'(bus.o_done), 0);
    checkOutput("resetValid", int'(bus.o_op_valid), 0);
    checkOutput("resetRdEn", int'(bus.o_rd_en), 0);
    checkOutput("resetOp", int'(bus.o_op), 0);
    checkOutput("resetRow", int'(bus.o_rd_row), 0);
    checkOutput("resetCol", int'(bus.o_rd_col), 0);
    checkOutput("resetCount", int'(bus.o_op_count), 0);

    for (int v = 0; v < 7; v++) begin
      fillMem(vecs[v].fill);
      modelWalk(vecs[v].endRow, vecs[v].endCol);
      applyStimulus(vecs[v].endRow, vecs[v].endCol, 1, -1, cyc, fv);
      checkOutput($sformatf("vec%0d count", v), int'(bus.o_op_count), vecs[v].expCount);
      checkOutput($sformatf("vec%0d reads", v), rdRowSeen.size(), vecs[v].expReads);
      checkOutput($sformatf("vec%0d firstRdRow", v),
                  (rdRowSeen.size() > 0) ? rdRowSeen[0] : -1, vecs[v].expFirstRow);
      checkOutput($sformatf("vec%0d firstRdCol", v),
                  (rdColSeen.size() > 0) ? rdColSeen[0] : -1, vecs[v].expFirstCol);
      checkOutput($sformatf("vec%0d doneLatency", v), cyc, vecs[v].expLatency);
      checkOutput($sformatf("vec%0d firstValid", v), fv, (vecs[v].expCount > 0) ? 3 : -1);
      compareSeq($sformatf("vec%0d ops", v), expOps, opsSeen);
      compareSeq($sformatf("vec%0d rdRows", v), expRow, rdRowSeen);
      tick();
      checkOutput($sformatf("vec%0d doneOneCycle", v), int'(bus.o_done), 0);
      checkOutput($sformatf("vec%0d idleBusy", v), int'(bus.o_busy), 0);
      checkOutput($sformatf("vec%0d countHeld", v), int'(bus.o_op_count), vecs[v].expCount);
    end

    // Gap chain in D: two extensions then a return to V, which then stops.
    fillMem(0);
    vMem[10][10] = 2'd2;
    dMem[10][10] = 1'b1;
    dMem[9][10] = 1'b1;
    dMem[8][10] = 1'b0;
    vMem[7][10] = 2'd3;
    applyStimulus(10, 10, 1, -1, cyc, fv);
    expOps.delete();
    expOps.push_back(2);
    expOps.push_back(2);
    expOps.push_back(2);
    compareSeq("dChain ops", expOps, opsSeen);
    checkOutput("dChain count", int'(bus.o_op_count), 3);
    checkOutput("dChain reads", rdRowSeen.size(), 4);
    checkOutput("dChain lastRdRow", (rdRowSeen.size() == 4) ? rdRowSeen[3] : -1, 7);
    checkOutput("dChain lastRdCol", (rdColSeen.size() == 4) ? rdColSeen[3] : -1, 10);
    tick();

    // A second start while busy must not disturb the running traceback.
    fillMem(0);
    modelWalk(5, 5);
    applyStimulus(5, 5, 1, 4, cyc, fv);
    checkOutput("ignoreStart count", int'(bus.o_op_count), 6);
    checkOutput("ignoreStart reads", rdRowSeen.size(), 6);
    compareSeq("ignoreStart rdCols", expCol, rdColSeen);
    tick();
    checkOutput("ignoreStart idle", int'(bus.o_busy), 0);

    // Stall the first op, then reset in the middle of the stall.
    fillMem(0);
    readyMode = 0;
    opsSeen.delete();
    rdRowSeen.delete();
    rdColSeen.delete();
    bus.i_end_row = 6'd5;
    bus.i_end_col = 10'd5;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    k = 0;
    while (!bus.o_op_valid && k < 20) begin
      tick();
      k++;
    end
    checkOutput("stall validSeen", int'(bus.o_op_valid), 1);
    savedOp = int'(bus.o_op);
    stable = 1'b1;
    repeat (5) begin
      tick();
      if (int'(bus.o_op) != savedOp || !bus.o_op_valid) stable = 1'b0;
    end
    checkOutput("stall opStable", int'(stable), 1);
    checkOutput("stall reads", rdRowSeen.size(), 1);
    checkOutput("stall count", int'(bus.o_op_count), 0);
    rst = 1'b1;
    tick();
    checkOutput("stallRst busy", int'(bus.o_busy), 0);
    checkOutput("stallRst valid", int'(bus.o_op_valid), 0);
    checkOutput("stallRst rdEn", int'(bus.o_rd_en), 0);
    checkOutput("stallRst done", int'(bus.o_done), 0);
    checkOutput("stallRst op", int'(bus.o_op), 0);
    checkOutput("stallRst row", int'(bus.o_rd_row), 0);
    checkOutput("stallRst col", int'(bus.o_rd_col), 0);
    checkOutput("stallRst count", int'(bus.o_op_count), 0);
    checkOutput("stallRst noOp", opsSeen.size(), 0);
    rst = 1'b0;
    readyMode = 1;
    tick();

    // Reset wins over a simultaneous start.
    rst = 1'b1;
    bus.i_end_row = 6'd5;
    bus.i_end_col = 10'd5;
    bus.i_start = 1'b1;
    tick();
    checkOutput("rstPrio busy", int'(bus.o_busy), 0);
    checkOutput("rstPrio rdEn", int'(bus.o_rd_en), 0);
    rst = 1'b0;
    bus.i_start = 1'b0;
    tick();
    checkOutput("rstPrio stillIdle", int'(bus.o_busy), 0);

    // Random matrices against the reference walk.
    for (int t = 0; t < 6; t++) begin
      fillMem(3);
      er = $urandom_range(0, 63);
      ec = $urandom_range(0, 460);
      mode = (t % 2 == 0) ? 1 : 2;
      modelWalk(er, ec);
      applyStimulus(er, ec, mode, -1, cyc, fv);
      checkOutput($sformatf("rnd%0d count", t), int'(bus.o_op_count), expOps.size());
      compareSeq($sformatf("rnd%0d ops", t), expOps, opsSeen);
      compareSeq($sformatf("rnd%0d rdRows", t), expRow, rdRowSeen);
      compareSeq($sformatf("rnd%0d rdCols", t), expCol, rdColSeen);
      if (mode == 1)
        checkOutput($sformatf("rnd%0d doneLatency", t), cyc,
                    3 * mReadOps + mFlushOps + (mStopped ? 3 : 1));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
